// File: rtl/keycode_sequencer.sv
// Queues USB HID keycodes and plays each one on the keycode output for a fixed
// number of frames, optionally followed by a run of 8'h00 frames before the next key.
module keycode_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_FRAMES = 8,
  parameter int GAP_FRAMES  = 1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_keycode,
  output logic       wr_ready,
  input  logic       flush,
  input  logic       clr_overflow,
  output logic [7:0] keycode,
  output logic [4:0] fifo_count,
  output logic       overflow,
  output logic       busy
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] GAP_INIT  = (GAP_FRAMES > 0) ? 8'(GAP_FRAMES - 1) : 8'h00;
  localparam bit         GAP_EN    = (GAP_FRAMES > 0);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      keycode_q, keycode_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic            push, pop, drop, fifo_nonempty;
  logic [7:0]      head;

  assign wr_ready      = (count_q < DEPTH_C);
  assign fifo_nonempty = (count_q != 5'd0);
  assign head          = mem_q[rd_ptr_q];
  assign keycode       = keycode_q;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != IDLE) || fifo_nonempty;

  always_comb begin
    push       = wr_valid && wr_ready && !flush && (wr_keycode != 8'h00);
    drop       = wr_valid && !wr_ready && !flush && (wr_keycode != 8'h00);
    // A drop at the same edge as a clear keeps the flag set.
    overflow_d = drop || (overflow_q && !clr_overflow);

    pop        = 1'b0;
    state_d    = state_q;
    keycode_d  = keycode_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        keycode_d = 8'h00;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          keycode_d  = head;
          hold_cnt_d = HOLD_INIT;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q != 8'h00) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end else if (GAP_EN) begin
          state_d   = GAP;
          keycode_d = 8'h00;
          gap_cnt_d = GAP_INIT;
        end else if (fifo_nonempty) begin
          pop        = 1'b1;
          keycode_d  = head;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d   = IDLE;
          keycode_d = 8'h00;
        end
      end
      GAP: begin
        keycode_d = 8'h00;
        if (gap_cnt_q != 8'h00) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else if (fifo_nonempty) begin
          pop        = 1'b1;
          keycode_d  = head;
          hold_cnt_d = HOLD_INIT;
          state_d    = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        keycode_d = 8'h00;
      end
    endcase

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_keycode;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {4'd0, push} - {4'd0, pop};

    // Flush wins over everything except the overflow flag.
    if (flush) begin
      state_d    = IDLE;
      keycode_d  = 8'h00;
      hold_cnt_d = 8'h00;
      gap_cnt_d  = 8'h00;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = 5'd0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      keycode_q  <= 8'h00;
      hold_cnt_q <= 8'h00;
      gap_cnt_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      keycode_q  <= keycode_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is only readable through the pointers, so it needs no reset.
  always_ff @(posedge frame_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_keycode_sequencer.sv
// Directed-vector bench for keycode_sequencer: stimulus queues expected per-frame
// outputs; a negedge monitor compares them against the DUT at their due frame.
module tb_keycode_sequencer;

  logic       frame_clk;
  logic       Reset;
  logic       wr_valid;
  logic [7:0] wr_keycode;
  logic       wr_ready;
  logic       flush;
  logic       clr_overflow;
  logic [7:0] keycode;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       busy;

  keycode_sequencer #(.DEPTH(4), .HOLD_FRAMES(8), .GAP_FRAMES(1)) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .wr_valid     (wr_valid),
    .wr_keycode   (wr_keycode),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .keycode      (keycode),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int cycle = 0;
  always @(posedge frame_clk) cycle <= cycle + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] kc;
    logic [4:0] cnt;
    logic       ovf;
    logic       bsy;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // off = number of edges from now after which the state is checked (0 = current frame)
  task automatic expect_at(input int off, input string name, input int kc, input int cnt,
                           input bit ovf, input bit bsy, input bit rdy);
    exp_t e;
    e.cyc  = cycle + off;
    e.name = name;
    e.kc   = 8'(kc);
    e.cnt  = 5'(cnt);
    e.ovf  = ovf;
    e.bsy  = bsy;
    e.rdy  = rdy;
    sb.push_back(e);
  endtask

  always @(negedge frame_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (done || sb[i].cyc <= cycle) begin
        n_tests++;
        if (sb[i].cyc != cycle) begin
          n_fail++;
          $display("FAIL %s: check for frame %0d never ran (now %0d)", sb[i].name, sb[i].cyc, cycle);
        end else if (keycode !== sb[i].kc || fifo_count !== sb[i].cnt || overflow !== sb[i].ovf ||
                     busy !== sb[i].bsy || wr_ready !== sb[i].rdy) begin
          n_fail++;
          $display("FAIL %s @%0d: got kc=%h cnt=%0d ovf=%b busy=%b rdy=%b, expected kc=%h cnt=%0d ovf=%b busy=%b rdy=%b",
                   sb[i].name, cycle, keycode, fifo_count, overflow, busy, wr_ready,
                   sb[i].kc, sb[i].cnt, sb[i].ovf, sb[i].bsy, sb[i].rdy);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_in();
    wr_valid     = 1'b0;
    wr_keycode   = 8'h00;
    flush        = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic write(input logic [7:0] k);
    wr_valid   = 1'b1;
    wr_keycode = k;
  endtask

  logic [7:0] wseq [5];
  logic [7:0] played [4];

  initial begin
    wseq   = '{8'h07, 8'h16, 8'h1A, 8'h04, 8'h07};
    played = '{8'h07, 8'h16, 8'h1A, 8'h04};
    Reset = 1'b1;
    idle_in();

    // reset state
    tick();
    expect_at(0, "in_reset", 0, 0, 0, 0, 1);
    tick();
    Reset = 1'b0;
    expect_at(0, "after_reset", 0, 0, 0, 0, 1);
    tick();

    // single key: 8 hold frames, 1 gap frame, then idle
    write(8'h04);
    expect_at(1, "single_accept", 0, 1, 0, 1, 1);
    for (int t = 2; t <= 9; t++) expect_at(t, "single_hold", 8'h04, 0, 0, 1, 1);
    expect_at(10, "single_gap", 0, 0, 0, 1, 1);
    expect_at(11, "single_idle", 0, 0, 0, 0, 1);
    tick();
    idle_in();
    ticks(11);

    // zero keycode is ignored
    write(8'h00);
    expect_at(1, "zero_write", 0, 0, 0, 0, 1);
    expect_at(2, "zero_write_after", 0, 0, 0, 0, 1);
    tick();
    idle_in();
    ticks(2);

    // fill during hold, overflow on fifth write, then ordered playback
    write(8'h04);
    expect_at(1, "ovf_first", 0, 1, 0, 1, 1);
    for (int t = 2; t <= 9; t++) begin
      int c;
      c = (t <= 2) ? 0 : ((t >= 6) ? 4 : t - 2);
      expect_at(t, "ovf_fill", 8'h04, c, (t >= 7), 1, (c < 4));
    end
    expect_at(10, "ovf_gap0", 0, 4, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 8; h++)
        expect_at(11 + 9 * k + h, "play_hold", played[k], 3 - k, 1, 1, 1);
      expect_at(19 + 9 * k, "play_gap", 0, 3 - k, 1, 1, 1);
    end
    expect_at(47, "play_idle", 0, 0, 1, 0, 1);
    tick();
    idle_in();
    tick();
    for (int i = 0; i < 5; i++) begin
      write(wseq[i]);
      tick();
    end
    idle_in();
    ticks(41);

    // flush during hold with two queued and a same-cycle write; overflow untouched
    write(8'h04);
    expect_at(1, "flush_acc", 0, 1, 1, 1, 1);
    expect_at(2, "flush_hold", 8'h04, 0, 1, 1, 1);
    expect_at(3, "flush_q1", 8'h04, 1, 1, 1, 1);
    expect_at(4, "flush_q2", 8'h04, 2, 1, 1, 1);
    expect_at(5, "flush_edge", 0, 0, 1, 0, 1);
    expect_at(6, "flush_after", 0, 0, 1, 0, 1);
    tick();
    idle_in();
    tick();
    write(8'h07);
    tick();
    write(8'h16);
    tick();
    write(8'h16);
    flush = 1'b1;
    tick();
    idle_in();
    ticks(2);

    // clear overflow
    clr_overflow = 1'b1;
    expect_at(1, "clr_ovf", 0, 0, 0, 0, 1);
    tick();
    idle_in();
    tick();

    // set and clear at the same edge: set wins
    expect_at(1, "sc_acc", 0, 1, 0, 1, 1);
    expect_at(2, "sc_pushpop", 8'h04, 1, 0, 1, 1);
    expect_at(3, "sc_q2", 8'h04, 2, 0, 1, 1);
    expect_at(4, "sc_q3", 8'h04, 3, 0, 1, 1);
    expect_at(5, "sc_full", 8'h04, 4, 0, 1, 0);
    expect_at(6, "sc_setwins", 8'h04, 4, 1, 1, 0);
    expect_at(7, "sc_flush", 0, 0, 1, 0, 1);
    expect_at(8, "sc_clear", 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      write(8'(8'h04 + i));
      tick();
    end
    write(8'h09);
    clr_overflow = 1'b1;
    tick();
    idle_in();
    flush = 1'b1;
    tick();
    idle_in();
    clr_overflow = 1'b1;
    tick();
    idle_in();
    tick();

    // asynchronous reset mid-hold drops active and queued keys
    write(8'h1A);
    expect_at(1, "rst_acc", 0, 1, 0, 1, 1);
    expect_at(2, "rst_hold", 8'h1A, 1, 0, 1, 1);
    tick();
    write(8'h07);
    tick();
    idle_in();
    tick();
    #1;
    Reset = 1'b1;
    expect_at(0, "rst_async", 0, 0, 0, 0, 1);
    tick();
    #2;
    Reset = 1'b0;
    for (int t = 1; t <= 3; t++) expect_at(t, "rst_quiet", 0, 0, 0, 0, 1);
    ticks(4);

    ticks(2);
    done = 1'b1;
    @(negedge frame_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
